// File: rtl/digits_pkg.sv
// Shared constants, FSM encoding and the segment-to-row raster rule for the digits path.
package digits_pkg;
  localparam int NUM_SEGS    = 7;
  localparam int ROW_W       = 5;
  localparam int NUM_LINES   = 8;
  localparam int GLYPH_LINES = 5;

  localparam int SEG_TOP = 6;
  localparam int SEG_UL  = 5;
  localparam int SEG_LL  = 4;
  localparam int SEG_BOT = 3;
  localparam int SEG_LR  = 2;
  localparam int SEG_UR  = 1;
  localparam int SEG_MID = 0;

  // Pixel columns sampled by the decoder: left edge, centre, right edge.
  localparam int COL_L = 0;
  localparam int COL_C = 2;
  localparam int COL_R = 4;

  localparam logic [ROW_W-1:0] ROW_F = 5'b11111;
  localparam logic [ROW_W-1:0] ROW_L = 5'b00001;
  localparam logic [ROW_W-1:0] ROW_R = 5'b10000;

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_DECODE, ST_CHECK, ST_DONE} state_t;

  // Strokes are XOR-combined, so corners shared by two strokes cancel.
  function automatic logic [ROW_W-1:0] enc_row(input logic [NUM_SEGS-1:0] s,
                                               input logic [2:0]          ln);
    logic [ROW_W-1:0] r;
    r = '0;
    case (ln)
      3'd0: r = ({ROW_W{s[SEG_TOP]}} & ROW_F) ^ ({ROW_W{s[SEG_UL]}} & ROW_L) ^
                ({ROW_W{s[SEG_UR]}} & ROW_R);
      3'd1: r = ({ROW_W{s[SEG_UR]}} & ROW_R) ^ ({ROW_W{s[SEG_UL]}} & ROW_L);
      3'd2: r = ({ROW_W{s[SEG_MID]}} & ROW_F) ^
                ({ROW_W{s[SEG_UL] | s[SEG_LL]}} & ROW_L) ^
                ({ROW_W{s[SEG_LR] | s[SEG_UR]}} & ROW_R);
      3'd3: r = ({ROW_W{s[SEG_LR]}} & ROW_R) ^ ({ROW_W{s[SEG_LL]}} & ROW_L);
      3'd4: r = ({ROW_W{s[SEG_BOT]}} & ROW_F) ^ ({ROW_W{s[SEG_LL]}} & ROW_L) ^
                ({ROW_W{s[SEG_LR]}} & ROW_R);
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/bitmap_to_segments.sv
// Scans an 8x5 glyph bitmap, recovers its 7-segment code and flags bitmaps that
// are not the exact raster of that code.
module bitmap_to_segments import digits_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROW_W-1:0]    bits,
  output logic [2:0]          line,
  output logic                busy,
  output logic [NUM_SEGS-1:0] segments,
  output logic                valid,
  output logic                error
);
  state_t           state;
  logic [ROW_W-1:0] row_buf [NUM_LINES];
  logic [2:0]       chk;
  logic             err_acc;
  logic             tail_err;
  logic             err_next;

  // Lines below the glyph must be blank; folded in on the first check cycle.
  always_comb begin
    tail_err = 1'b0;
    for (int i = GLYPH_LINES; i < NUM_LINES; i++) tail_err = tail_err | (|row_buf[i]);
    err_next = err_acc | (row_buf[chk] != enc_row(segments, chk)) |
               ((chk == 3'd0) & tail_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      line     <= '0;
      busy     <= 1'b0;
      segments <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
      chk      <= '0;
      err_acc  <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) row_buf[i] <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_SCAN;
          line    <= '0;
          busy    <= 1'b1;
          err_acc <= 1'b0;
          error   <= 1'b0;
        end
        ST_SCAN: begin
          row_buf[line] <= bits;
          if (line == 3'(NUM_LINES - 1)) begin
            line  <= '0;
            state <= ST_DECODE;
          end else begin
            line <= line + 3'd1;
          end
        end
        ST_DECODE: begin
          segments[SEG_TOP] <= row_buf[0][COL_C];
          segments[SEG_MID] <= row_buf[2][COL_C];
          segments[SEG_BOT] <= row_buf[4][COL_C];
          segments[SEG_UR]  <= row_buf[1][COL_R];
          segments[SEG_UL]  <= row_buf[1][COL_L];
          segments[SEG_LR]  <= row_buf[3][COL_R];
          segments[SEG_LL]  <= row_buf[3][COL_L];
          chk   <= '0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          err_acc <= err_next;
          if (chk == 3'(GLYPH_LINES - 1)) begin
            error <= err_next;
            valid <= 1'b1;
            state <= ST_DONE;
          end else begin
            chk <= chk + 3'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
